axi_rd_slave_router: RTL and testbench

Parametrised read-channel slave router for the AXI4 interconnect, placed between a master-side arbiter output and NUM_SLAVES read slaves. It decodes the slave index from the top address bits and forwards AR to that slave. It then steers the slave's R beats back until every accepted burst has returned RLAST. Unlike the fixed 8-slave mux, it tracks outstanding bursts, stalls AR that would reorder responses, and answers unmapped addresses itself with DECERR bursts.

---
 rtl/axi_ic_pkg.sv | 18 +
 rtl/axi_rd_slave_router_if.sv | 52 +++++
 rtl/axi_rd_decerr_gen.sv | 44 ++++
 rtl/axi_rd_slave_router.sv | 147 ++++++++++++++
 tb/tb_axi_rd_slave_router.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_ic_pkg.sv
// Shared AXI interconnect definitions: response codes, router state encoding
// and default widths used by the read-path blocks.
package axi_ic_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int ID_W_DEF   = 4;
    localparam int USER_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROUTE  = 2'd1,
        DECERR = 2'd2
    } rt_state_t;

endpackage

// File: rtl/axi_rd_slave_router_if.sv
// Read-channel bundle between the arbiter output (m_*) and the attached slaves (s_*).
// Handshakes: a beat transfers on the rising ACLK edge where VALID and READY are both high;
// VALID never waits on READY, and payload is held stable while VALID is high and READY low.
interface axi_rd_slave_router_if
    import axi_ic_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = ID_W_DEF,
    parameter int USER_WIDTH = USER_W_DEF,
    parameter int NUM_SLAVES = 8
);
    logic [ADDR_WIDTH-1:0]            m_ARADDR;
    logic [7:0]                       m_ARLEN;
    logic [ID_WIDTH-1:0]              m_ARID;
    logic                             m_ARVALID;
    logic                             m_ARREADY;
    logic [ID_WIDTH-1:0]              m_RID;
    logic [DATA_WIDTH-1:0]            m_RDATA;
    logic [1:0]                       m_RRESP;
    logic                             m_RLAST;
    logic [USER_WIDTH-1:0]            m_RUSER;
    logic                             m_RVALID;
    logic                             m_RREADY;

    logic [NUM_SLAVES-1:0]            s_ARVALID;
    logic [NUM_SLAVES-1:0]            s_ARREADY;
    logic [NUM_SLAVES*ID_WIDTH-1:0]   s_RID;
    logic [NUM_SLAVES*DATA_WIDTH-1:0] s_RDATA;
    logic [NUM_SLAVES*USER_WIDTH-1:0] s_RUSER;
    logic [NUM_SLAVES*2-1:0]          s_RRESP;
    logic [NUM_SLAVES-1:0]            s_RLAST;
    logic [NUM_SLAVES-1:0]            s_RVALID;
    logic [NUM_SLAVES-1:0]            s_RREADY;

    // Router view.
    modport slave (
        input  m_ARADDR, m_ARLEN, m_ARID, m_ARVALID, m_RREADY,
        input  s_ARREADY, s_RID, s_RDATA, s_RUSER, s_RRESP, s_RLAST, s_RVALID,
        output m_ARREADY, m_RID, m_RDATA, m_RRESP, m_RLAST, m_RUSER, m_RVALID,
        output s_ARVALID, s_RREADY
    );

    // Environment view: upstream master plus the slave models.
    modport master (
        output m_ARADDR, m_ARLEN, m_ARID, m_ARVALID, m_RREADY,
        output s_ARREADY, s_RID, s_RDATA, s_RUSER, s_RRESP, s_RLAST, s_RVALID,
        input  m_ARREADY, m_RID, m_RDATA, m_RRESP, m_RLAST, m_RUSER, m_RVALID,
        input  s_ARVALID, s_RREADY
    );

endinterface

// File: rtl/axi_rd_decerr_gen.sv
// Emits a DECERR read burst of load_len+1 beats carrying load_id, starting the
// cycle after the load pulse and advancing one beat per accepted handshake.
module axi_rd_decerr_gen
    import axi_ic_pkg::*;
#(
    parameter int ID_WIDTH = ID_W_DEF
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic                load,
    input  logic [ID_WIDTH-1:0] load_id,
    input  logic [7:0]          load_len,
    input  logic                rready,
    output logic                rvalid,
    output logic [ID_WIDTH-1:0] rid,
    output logic [1:0]          rresp,
    output logic                rlast
);
    logic                busy;
    logic [ID_WIDTH-1:0] err_id;
    logic [7:0]          err_cnt;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            busy    <= 1'b0;
            err_id  <= '0;
            err_cnt <= '0;
        end else if (load) begin
            busy    <= 1'b1;
            err_id  <= load_id;
            err_cnt <= load_len;
        end else if (busy && rready) begin
            // err_cnt counts beats still to send after the current one
            if (err_cnt == 8'd0) busy <= 1'b0;
            else                 err_cnt <= err_cnt - 8'd1;
        end
    end

    assign rvalid = busy;
    assign rid    = err_id;
    assign rresp  = RESP_DECERR;
    assign rlast  = (err_cnt == 8'd0);

endmodule

// File: rtl/axi_rd_slave_router.sv
// AR decode and R steering to NUM_SLAVES read slaves; keeps per-slave ordering by
// locking onto one slave while bursts are outstanding and answers unmapped reads with DECERR.
module axi_rd_slave_router
    import axi_ic_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = ID_W_DEF,
    parameter int USER_WIDTH = USER_W_DEF,
    parameter int NUM_SLAVES = 8,
    parameter int MAX_OUT    = 4,
    localparam int SEL_W     = $clog2(NUM_SLAVES),
    localparam int CNT_W     = $clog2(MAX_OUT + 1)
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    axi_rd_slave_router_if.slave  bus,
    output rt_state_t             dbg_state,
    output logic [CNT_W-1:0]      dbg_out_cnt
);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

    rt_state_t        state, state_nxt;
    logic [SEL_W-1:0] cur_sel;
    logic [SEL_W-1:0] dec_idx;
    logic [CNT_W-1:0] out_cnt;
    logic             mapped, admit;
    logic             ar_hs, map_hs, err_hs, rlast_hs, decerr_done;
    logic             gen_rvalid, gen_rlast;
    logic [ID_WIDTH-1:0] gen_rid;
    logic [1:0]       gen_rresp;
    logic             addr_unused;

    assign dec_idx     = bus.m_ARADDR[ADDR_WIDTH-1 -: SEL_W];
    assign addr_unused = ^bus.m_ARADDR[ADDR_WIDTH-SEL_W-1:0];
    assign mapped      = ({{(32-SEL_W){1'b0}}, dec_idx} < 32'(NUM_SLAVES));

    assign rlast_hs    = (state == ROUTE) && bus.m_RVALID && bus.m_RREADY && bus.m_RLAST;
    assign decerr_done = (state == DECERR) && gen_rvalid && bus.m_RREADY && gen_rlast;

    // A burst retiring this cycle frees its slot, so a full slave can still take the next AR.
    assign admit = (state == IDLE) ||
                   ((state == ROUTE) && (dec_idx == cur_sel) &&
                    ((out_cnt < MAX_CNT) || rlast_hs));

    assign ar_hs  = bus.m_ARVALID && bus.m_ARREADY;
    assign map_hs = ar_hs && mapped;
    assign err_hs = ar_hs && !mapped;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (map_hs)      state_nxt = ROUTE;
                else if (err_hs) state_nxt = DECERR;
            end
            ROUTE: begin
                if (rlast_hs && !map_hs && (out_cnt == CNT_W'(1))) state_nxt = IDLE;
            end
            DECERR: begin
                if (decerr_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            cur_sel <= '0;
            out_cnt <= '0;
        end else begin
            if (map_hs) cur_sel <= dec_idx;
            if (map_hs && !rlast_hs)      out_cnt <= out_cnt + CNT_W'(1);
            else if (!map_hs && rlast_hs) out_cnt <= out_cnt - CNT_W'(1);
        end
    end

    // AR steering: only the decoded slave sees ARVALID, and only when admissible.
    always_comb begin
        bus.s_ARVALID = '0;
        bus.m_ARREADY = 1'b0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (admit && mapped && (dec_idx == SEL_W'(k))) begin
                bus.s_ARVALID[k] = bus.m_ARVALID;
                bus.m_ARREADY    = bus.s_ARREADY[k];
            end
        end
        if ((state == IDLE) && !mapped) bus.m_ARREADY = 1'b1;
    end

    // R steering: the locked slave in ROUTE, the local generator in DECERR, silence in IDLE.
    always_comb begin
        bus.s_RREADY = '0;
        bus.m_RVALID = 1'b0;
        bus.m_RID    = '0;
        bus.m_RDATA  = '0;
        bus.m_RRESP  = '0;
        bus.m_RLAST  = 1'b0;
        bus.m_RUSER  = '0;
        unique case (state)
            ROUTE: begin
                for (int k = 0; k < NUM_SLAVES; k++) begin
                    if (cur_sel == SEL_W'(k)) begin
                        bus.m_RVALID    = bus.s_RVALID[k];
                        bus.m_RID       = bus.s_RID[k*ID_WIDTH +: ID_WIDTH];
                        bus.m_RDATA     = bus.s_RDATA[k*DATA_WIDTH +: DATA_WIDTH];
                        bus.m_RRESP     = bus.s_RRESP[k*2 +: 2];
                        bus.m_RLAST     = bus.s_RLAST[k];
                        bus.m_RUSER     = bus.s_RUSER[k*USER_WIDTH +: USER_WIDTH];
                        bus.s_RREADY[k] = bus.m_RREADY;
                    end
                end
            end
            DECERR: begin
                bus.m_RVALID = gen_rvalid;
                bus.m_RID    = gen_rid;
                bus.m_RRESP  = gen_rresp;
                bus.m_RLAST  = gen_rlast;
            end
            default: ;
        endcase
    end

    axi_rd_decerr_gen #(
        .ID_WIDTH (ID_WIDTH)
    ) u_decerr_gen (
        .ACLK     (ACLK),
        .ARESETn  (ARESETn),
        .load     (err_hs),
        .load_id  (bus.m_ARID),
        .load_len (bus.m_ARLEN),
        .rready   (bus.m_RREADY),
        .rvalid   (gen_rvalid),
        .rid      (gen_rid),
        .rresp    (gen_rresp),
        .rlast    (gen_rlast)
    );

    assign dbg_state   = state;
    assign dbg_out_cnt = out_cnt;

endmodule

// File: tb/tb_axi_rd_slave_router.sv
// Directed bench for axi_rd_slave_router with six slaves (indices 6 and 7 unmapped);
// expected R beats go into a queue and a negedge monitor compares each master-side handshake.
module tb_axi_rd_slave_router;
    import axi_ic_pkg::*;

    localparam int DW = 64;
    localparam int AW = 32;
    localparam int IW = 4;
    localparam int UW = 4;
    localparam int NS = 6;
    localparam int MO = 4;
    localparam int SW = 3;
    localparam int CW = 3;
    localparam int BW = IW + DW + 2 + 1 + UW;

    logic ACLK = 1'b0;
    logic ARESETn;
    rt_state_t dbg_state;
    logic [CW-1:0] dbg_out_cnt;

    logic [BW-1:0] exp_q[$];
    logic [BW-1:0] exp_beat;
    int n_checks = 0;
    int n_pass   = 0;

    always #5 ACLK = ~ACLK;

    axi_rd_slave_router_if #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .USER_WIDTH(UW), .NUM_SLAVES(NS)
    ) bus ();

    axi_rd_slave_router #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .USER_WIDTH(UW),
        .NUM_SLAVES(NS), .MAX_OUT(MO)
    ) dut (
        .ACLK        (ACLK),
        .ARESETn     (ARESETn),
        .bus         (bus),
        .dbg_state   (dbg_state),
        .dbg_out_cnt (dbg_out_cnt)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic set_ar(input logic v, input int idx, input logic [IW-1:0] id, input logic [7:0] len);
        bus.m_ARVALID = v;
        bus.m_ARADDR  = AW'(idx) << (AW - SW);
        bus.m_ARID    = id;
        bus.m_ARLEN   = len;
    endtask

    task automatic beat(input int k, input logic [IW-1:0] id, input logic [DW-1:0] data,
                        input logic [UW-1:0] user, input logic last);
        bus.s_RVALID[k]           = 1'b1;
        bus.s_RID[k*IW +: IW]     = id;
        bus.s_RDATA[k*DW +: DW]   = data;
        bus.s_RUSER[k*UW +: UW]   = user;
        bus.s_RRESP[k*2 +: 2]     = RESP_OKAY;
        bus.s_RLAST[k]            = last;
        exp_q.push_back({id, data, RESP_OKAY, last, user});
    endtask

    task automatic beat_off(input int k);
        bus.s_RVALID[k] = 1'b0;
        bus.s_RLAST[k]  = 1'b0;
    endtask

    task automatic wait_r_hs(input int k);
        logic hs;
        hs = 1'b0;
        for (int c = 0; c < 50 && !hs; c++) begin
            @(negedge ACLK);
            hs = bus.s_RVALID[k] && bus.s_RREADY[k];
            @(posedge ACLK);
            #1;
        end
        check("slave_r_handshake", hs, 1'b1);
    endtask

    task automatic send_r(input int k, input logic [IW-1:0] id, input int n);
        for (int b = 0; b < n; b++) begin
            beat(k, id, 64'hA5A5_0000_0000_0000 + 64'(k * 256 + b), UW'(b), b == n - 1);
            wait_r_hs(k);
        end
        beat_off(k);
    endtask

    // Monitor: every master-side R handshake must match the head of the expected queue.
    always @(negedge ACLK) begin
        if (ARESETn && bus.m_RVALID && bus.m_RREADY) begin
            check("r_beat_expected", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
                exp_beat = exp_q.pop_front();
                check("r_beat", {bus.m_RID, bus.m_RDATA, bus.m_RRESP, bus.m_RLAST, bus.m_RUSER}, exp_beat);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [7:0] pat;
        ARESETn       = 1'b0;
        set_ar(1'b0, 0, '0, '0);
        bus.m_RREADY  = 1'b1;
        bus.s_ARREADY = '1;
        bus.s_RVALID  = '0;
        bus.s_RLAST   = '0;
        bus.s_RID     = '0;
        bus.s_RDATA   = '0;
        bus.s_RUSER   = '0;
        bus.s_RRESP   = '0;
        #1;
        check("rst_state", dbg_state, IDLE);
        check("rst_out_cnt", dbg_out_cnt, 0);
        check("rst_m_rvalid", bus.m_RVALID, 1'b0);
        check("rst_s_rready", bus.s_RREADY, 6'b0);
        check("rst_m_arready_idle_decode", bus.m_ARREADY, 1'b1);
        step(); step(); step();
        ARESETn = 1'b1;
        step();

        // Mapped burst to slave 3, first held off by the slave's ARREADY.
        bus.s_ARREADY[3] = 1'b0;
        set_ar(1'b1, 3, 4'h5, 8'd3);
        #1;
        check("t1_s_arvalid", bus.s_ARVALID, 6'b001000);
        check("t1_arready_follows_slave", bus.m_ARREADY, 1'b0);
        step();
        bus.s_ARREADY[3] = 1'b1;
        #1;
        check("t1_m_arready", bus.m_ARREADY, 1'b1);
        step();
        set_ar(1'b0, 0, '0, '0);
        #1;
        check("t1_state_route", dbg_state, ROUTE);
        check("t1_out_cnt_1", dbg_out_cnt, 1);
        send_r(3, 4'h5, 4);
        check("t1_state_idle", dbg_state, IDLE);
        check("t1_out_cnt_0", dbg_out_cnt, 0);

        // Outstanding limit on slave 2.
        for (int i = 0; i < 4; i++) begin
            set_ar(1'b1, 2, IW'(i), 8'd0);
            #1;
            check("t2_accept", bus.m_ARREADY, 1'b1);
            step();
        end
        set_ar(1'b1, 2, 4'h4, 8'd0);
        #1;
        check("t2_full_out_cnt", dbg_out_cnt, 4);
        check("t2_fifth_stalled", bus.m_ARREADY, 1'b0);
        check("t2_fifth_no_s_arvalid", bus.s_ARVALID, 6'b0);
        step();
        check("t2_still_stalled", bus.m_ARREADY, 1'b0);
        beat(2, 4'h0, 64'h0000_0000_2222_0000, 4'h7, 1'b1);
        #1;
        check("t2_accept_with_rlast", bus.m_ARREADY, 1'b1);
        check("t2_s_arvalid", bus.s_ARVALID, 6'b000100);
        step();
        beat_off(2);
        set_ar(1'b0, 0, '0, '0);
        #1;
        check("t2_out_cnt_stays_4", dbg_out_cnt, 4);
        check("t2_state_route", dbg_state, ROUTE);
        for (int i = 1; i < 5; i++) send_r(2, IW'(i), 1);
        check("t2_state_idle", dbg_state, IDLE);
        check("t2_out_cnt_0", dbg_out_cnt, 0);

        // Ordering stall: slave 5 waits for slave 1 to finish.
        set_ar(1'b1, 1, 4'h6, 8'd1);
        step();
        set_ar(1'b1, 5, 4'h7, 8'd0);
        #1;
        check("t3_stall_arready", bus.m_ARREADY, 1'b0);
        check("t3_stall_s_arvalid", bus.s_ARVALID, 6'b0);
        step();
        beat(1, 4'h6, 64'h1111_0000_0000_0000, 4'h0, 1'b0);
        step();
        beat(1, 4'h6, 64'h1111_0000_0000_0001, 4'h1, 1'b1);
        #1;
        check("t3_stall_during_rlast", bus.m_ARREADY, 1'b0);
        check("t3_stall_s_arvalid_rlast", bus.s_ARVALID, 6'b0);
        step();
        beat_off(1);
        #1;
        check("t3_idle_after_rlast", dbg_state, IDLE);
        check("t3_accept_next", bus.m_ARREADY, 1'b1);
        check("t3_s_arvalid_5", bus.s_ARVALID, 6'b100000);
        step();
        set_ar(1'b0, 0, '0, '0);
        #1;
        check("t3_route_5", dbg_state, ROUTE);
        check("t3_out_cnt_1", dbg_out_cnt, 1);
        send_r(5, 4'h7, 1);
        check("t3_state_idle", dbg_state, IDLE);

        // Decode error, index 7, three beats with a stalling master.
        set_ar(1'b1, 7, 4'hA, 8'd2);
        #1;
        check("t4_unmapped_arready", bus.m_ARREADY, 1'b1);
        check("t4_unmapped_no_s_arvalid", bus.s_ARVALID, 6'b0);
        exp_q.push_back({4'hA, 64'h0, 2'b11, 1'b0, 4'h0});
        exp_q.push_back({4'hA, 64'h0, 2'b11, 1'b0, 4'h0});
        exp_q.push_back({4'hA, 64'h0, 2'b11, 1'b1, 4'h0});
        bus.m_RREADY = 1'b0;
        step();
        set_ar(1'b1, 0, 4'h1, 8'd0);
        #1;
        check("t4_first_beat_valid", bus.m_RVALID, 1'b1);
        check("t4_first_beat_resp", bus.m_RRESP, 2'b11);
        check("t4_state_decerr", dbg_state, DECERR);
        check("t4_ar_stalled", bus.m_ARREADY, 1'b0);
        check("t4_ar_no_s_arvalid", bus.s_ARVALID, 6'b0);
        set_ar(1'b0, 0, '0, '0);
        pat = 8'b1011_0010;
        for (int c = 0; c < 40 && dbg_state != IDLE; c++) begin
            bus.m_RREADY = pat[c % 8];
            step();
        end
        bus.m_RREADY = 1'b1;
        check("t4_state_idle", dbg_state, IDLE);

        // Single-beat DECERR at index 6.
        set_ar(1'b1, 6, 4'h3, 8'd0);
        exp_q.push_back({4'h3, 64'h0, 2'b11, 1'b1, 4'h0});
        step();
        set_ar(1'b0, 0, '0, '0);
        #1;
        check("t4b_rlast_first_beat", bus.m_RLAST, 1'b1);
        step();
        check("t4b_state_idle", dbg_state, IDLE);

        // Reset with two bursts outstanding on slave 4.
        set_ar(1'b1, 4, 4'h2, 8'd0);
        step();
        step();
        set_ar(1'b0, 0, '0, '0);
        #1;
        check("t5_out_cnt_2", dbg_out_cnt, 2);
        bus.s_RVALID[4] = 1'b1;
        ARESETn = 1'b0;
        #1;
        check("t5_rst_s_rready", bus.s_RREADY, 6'b0);
        check("t5_rst_m_rvalid", bus.m_RVALID, 1'b0);
        check("t5_rst_state", dbg_state, IDLE);
        check("t5_rst_out_cnt", dbg_out_cnt, 0);
        step();
        step();
        ARESETn = 1'b1;
        #1;
        check("t5_stray_s_rready", bus.s_RREADY, 6'b0);
        check("t5_stray_m_rvalid", bus.m_RVALID, 1'b0);
        bus.s_RVALID[4] = 1'b0;
        set_ar(1'b1, 0, 4'h9, 8'd0);
        #1;
        check("t5_new_arready", bus.m_ARREADY, 1'b1);
        check("t5_new_s_arvalid", bus.s_ARVALID, 6'b000001);
        step();
        set_ar(1'b0, 0, '0, '0);
        #1;
        check("t5_route", dbg_state, ROUTE);
        check("t5_out_cnt_1", dbg_out_cnt, 1);
        send_r(0, 4'h9, 1);
        check("t5_state_idle", dbg_state, IDLE);

        step();
        check("exp_q_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
